fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstN  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port imemReq  output  1  one-cycle request pulse to instruction memory.
REQ-005 SHALL have port imemAddr  output  32  word address, valid only while imemReq=1.
REQ-006 SHALL have port imemValid  input  1  response strobe, 1 or more cycles after request.
REQ-007 SHALL have port imemRdata  input  32  instruction word, valid with imemValid.
REQ-008 SHALL have port stallD  input  1  decode stage cannot accept a new instruction.
REQ-009 SHALL have port pcSrcD  input  1  branch taken; redirect and flush.
REQ-010 SHALL have port pcBranchD  input  32  redirect target.
REQ-011 SHALL have port instrD  output  32  IF/ID instruction register to control unit.
REQ-012 SHALL have port pcPlus4D  output  32  IF/ID PC+4 register.
REQ-013 SHALL have port validD  output  1  instrD/pcPlus4D hold a live instruction.

Function
REQ-014 SHALL implement states IDLE (nothing outstanding), WAIT (request outstanding), DROP (outstanding request squashed).
REQ-015 SHALL allow at most one outstanding memory request.
REQ-016 IDLE: SHALL issue (imemReq=1, imemAddr=pc) when skid empty, !(validD && stallD), !pcSrcD; on issue reqPc<=pc, pc<=pc+4, go WAIT.
REQ-017 WAIT with imemValid: if !validD || !stallD, load instrD<=imemRdata, pcPlus4D<=reqPc+4, validD<=1; else load the single-entry skid buffer; go IDLE.
REQ-018 SHALL move a full skid into IF/ID as soon as !validD || !stallD, then clear the skid.
REQ-019 When validD && !stallD and nothing is loaded, validD SHALL drop to 0 (instruction consumed).
REQ-020 While validD && stallD, instrD, pcPlus4D, and validD SHALL hold unchanged.
REQ-021 pcSrcD=1 SHALL take priority over stallD:
- pc<=pcBranchD with bits[1:0] forced to 00
- validD<=0; skid cleared
- WAIT without imemValid -> DROP
- WAIT with imemValid -> IDLE, response discarded
REQ-022 DROP: SHALL discard the response and go IDLE on imemValid; pcSrcD in DROP updates pc only.
REQ-023 SHALL ignore imemValid in IDLE.
REQ-024 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC+4 = 0.
REQ-025 Minimum latency SHALL be issue at cycle N, response at N+1, instrD visible after edge N+1, next issue at N+2.

Reset
REQ-026 While rstN=0, the block SHALL hold:
- pc=RESET_PC; state=IDLE; skid empty
- imemReq=0, imemAddr=0, instrD=0, pcPlus4D=0, validD=0
REQ-027 Reset mid-WAIT SHALL abandon the request; a late response SHALL be ignored per REQ-023.
REQ-028 First issue SHALL occur on the first rising edge with rstN=1.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, output fetchCount (32):
- resets to 0
- increments once per instruction loaded into IF/ID from memory or skid
- never counts dropped responses
- wraps at 2^32
REQ-030 Without FETCH_PERF_CNT_EN, fetchCount and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-031 Reset release, RESET_PC=0, memory latency 1, word at 0 = 32'h00430820 -> imemReq at cycle 0 with addr 0; instrD=32'h00430820, pcPlus4D=4, validD=1 after cycle 1.
REQ-032 stallD=1 held while the response for addr 4 arrives -> response captured in skid, no further imemReq; stallD=0 -> instrD shows addr-4 word next edge.
REQ-033 pcSrcD=1, pcBranchD=32'h00000103 while WAIT, response 2 cycles later -> response discarded, validD=0, next imemAddr=32'h00000100.
REQ-034 pcSrcD=1 same cycle as imemValid -> response discarded, validD=0, next issue from pcBranchD.
REQ-035 rstN=0 mid-WAIT, response arrives after release -> ignored; first issue at RESET_PC; with FETCH_PERF_CNT_EN, fetchCount=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end with one outstanding imem request, a one-entry skid and the IF/ID register.
// Latency: the request is issued combinationally from IDLE; the word appears in IF/ID on the edge that samples imemValid.
// Backpressure: stallD holds IF/ID. A response that cannot enter IF/ID parks in the skid, and new issue waits until it drains.
//
// Ports:
//   clk, rstN                 clock and asynchronous active-low reset
//   imemReq, imemAddr         one-cycle fetch request and word address (address is 0 when no request)
//   imemValid, imemRdata      memory response strobe and instruction word
//   stallD, pcSrcD, pcBranchD decode back-pressure and taken-branch redirect (redirect wins over stall)
//   instrD, pcPlus4D, validD  IF/ID register contents
//   fetchCount                instructions loaded into IF/ID (only when FETCH_PERF_CNT_EN is defined)
// Optional feature macro: FETCH_PERF_CNT_EN
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    input  logic        stallD,
    input  logic        pcSrcD,
    input  logic [31:0] pcBranchD,
    output logic [31:0] instrD,
    output logic [31:0] pcPlus4D,
    output logic        validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // nothing outstanding
        WAIT = 2'd1,  // request outstanding, response wanted
        DROP = 2'd2   // request outstanding, response squashed by a redirect
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;          // next address to fetch
    logic [31:0] req_pc;      // address of the outstanding request
    logic        skid_vld;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;

    logic        dec_free;    // IF/ID can take a new instruction this cycle
    logic        issue;
    logic        resp_load;   // response goes straight into IF/ID
    logic        resp_skid;   // response parks in the skid
    logic        skid_load;   // skid drains into IF/ID
    logic        ifid_load;

    assign dec_free  = !validD || !stallD;
    assign skid_load = skid_vld && dec_free && !pcSrcD;
    assign ifid_load = resp_load || skid_load;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        resp_load = 1'b0;
        resp_skid = 1'b0;
        case (state)
            IDLE: begin
                // rstN gates issue so the request stays low throughout reset
                // and the first request is seen on the first edge after release.
                if (rstN && !skid_vld && !(validD && stallD) && !pcSrcD) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imemValid) begin
                    state_nxt = IDLE;
                    // A redirect in the response cycle discards the word.
                    if (!pcSrcD) begin
                        if (dec_free) begin
                            resp_load = 1'b1;
                        end else begin
                            resp_skid = 1'b1;
                        end
                    end
                end else if (pcSrcD) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imemValid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        imemReq  = issue;
        imemAddr = issue ? pc : 32'h00000000;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc         <= RESET_PC;
            req_pc     <= 32'h00000000;
            skid_vld   <= 1'b0;
            skid_instr <= 32'h00000000;
            skid_pc4   <= 32'h00000000;
            instrD     <= 32'h00000000;
            pcPlus4D   <= 32'h00000000;
            validD     <= 1'b0;
        end else begin
            // Redirect target is forced word-aligned; pc wraps modulo 2^32.
            if (pcSrcD) begin
                pc <= pcBranchD & ~32'h00000003;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            if (issue) begin
                req_pc <= pc;
            end

            if (pcSrcD) begin
                validD   <= 1'b0;
                skid_vld <= 1'b0;
            end else if (resp_load) begin
                instrD   <= imemRdata;
                pcPlus4D <= req_pc + 32'd4;
                validD   <= 1'b1;
            end else if (skid_load) begin
                instrD   <= skid_instr;
                pcPlus4D <= skid_pc4;
                validD   <= 1'b1;
                skid_vld <= 1'b0;
            end else if (validD && !stallD) begin
                validD   <= 1'b0;
            end

            // Issue is blocked while the skid is full, so a response can
            // only reach here with the skid empty.
            if (resp_skid) begin
                skid_vld   <= 1'b1;
                skid_instr <= imemRdata;
                skid_pc4   <= req_pc + 32'd4;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetchCount <= 32'h00000000;
        end else if (ifid_load) begin
            fetchCount <= fetchCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized stall/redirect traffic.
// A memory responder answers each request after a configurable or random latency.
// A monitor checks fetch addresses and the consumed instruction stream against a program-order model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk       = 1'b0;
    logic        rstN      = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid = 1'b0;
    logic [31:0] imemRdata = 32'h00000000;
    logic        stallD    = 1'b0;
    logic        pcSrcD    = 1'b0;
    logic [31:0] pcBranchD = 32'h00000000;
    logic [31:0] instrD;
    logic [31:0] pcPlus4D;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount;
`endif

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemValid (imemValid),
        .imemRdata (imemRdata),
        .stallD    (stallD),
        .pcSrcD    (pcSrcD),
        .pcBranchD (pcBranchD),
        .instrD    (instrD),
        .pcPlus4D  (pcPlus4D),
        .validD    (validD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount(fetchCount)
`endif
    );

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    int consumed = 0;
    int lat_cfg = 1;                 // 0 selects a random latency 1..3
    logic [31:0] redir_q[$];         // redirect targets pushed by the stimulus

    // Program memory contents: word at 0 is the reference instruction.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h00000000) return 32'h00430820;
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] t);
        pcSrcD    = 1'b1;
        pcBranchD = t;
        redir_q.push_back(t);
    endtask

    // Memory responder: drives responses at negedge, samples requests at +2.
    bit          resp_pend = 1'b0;
    int          resp_dly  = 0;
    logic [31:0] resp_addr = 32'h00000000;
    always begin
        @(negedge clk);
        imemValid = 1'b0;
        imemRdata = $urandom;
        if (resp_pend) begin
            if (resp_dly <= 1) begin
                imemValid = 1'b1;
                imemRdata = mem_word(resp_addr);
                resp_pend = 1'b0;
            end else begin
                resp_dly = resp_dly - 1;
            end
        end
        #2;
        if (rstN && imemReq) begin
            resp_pend = 1'b1;
            resp_addr = imemAddr;
            resp_dly  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
        end
    end

    // Monitor: program-order model of fetch addresses and consumed instructions.
    logic [31:0] fetch_pc = RESET_PC;
    logic [31:0] exp_pc   = RESET_PC;
    bit          outstanding = 1'b0;
    bit          hold_prev   = 1'b0;
    bit          flush_prev  = 1'b0;
    logic [31:0] held_instr  = 32'h0;
    logic [31:0] held_pc4    = 32'h0;
    always begin
        logic [31:0] tgt;
        @(negedge clk);
        #1;
        if (!rstN) begin
            fetch_pc    = RESET_PC;
            exp_pc      = RESET_PC;
            outstanding = 1'b0;
            hold_prev   = 1'b0;
            flush_prev  = 1'b0;
        end else begin
            if (flush_prev) chk("mon_redirect_clears_valid", {31'b0, validD}, 32'd0);
            if (hold_prev) begin
                chk("mon_stall_hold_instr", instrD, held_instr);
                chk("mon_stall_hold_pc4", pcPlus4D, held_pc4);
                chk("mon_stall_hold_valid", {31'b0, validD}, 32'd1);
            end
            if (imemValid) outstanding = 1'b0;
            if (pcSrcD) begin
                tot++;
                if (redir_q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_redirect_queue: got empty expected one target");
                    tgt = pcBranchD;
                end else begin
                    tgt = redir_q.pop_front();
                end
                tgt      = {tgt[31:2], 2'b00};
                fetch_pc = tgt;
                exp_pc   = tgt;
                chk("mon_no_issue_on_redirect", {31'b0, imemReq}, 32'd0);
            end else begin
                if (imemReq) begin
                    chk("mon_single_outstanding", {31'b0, outstanding}, 32'd0);
                    chk("mon_fetch_addr", imemAddr, fetch_pc);
                    fetch_pc    = fetch_pc + 32'd4;
                    outstanding = 1'b1;
                end
                if (validD && !stallD) begin
                    chk("mon_consumed_instr", instrD, mem_word(exp_pc));
                    chk("mon_consumed_pc4", pcPlus4D, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
            end
            hold_prev  = validD && stallD && !pcSrcD;
            held_instr = instrD;
            held_pc4   = pcPlus4D;
            flush_prev = pcSrcD;
        end
    end

    initial begin
        int consumed_start;
        logic [31:0] t;

        // Reset state
        repeat (3) tick();
        #3;
        chk("reset_req", {31'b0, imemReq}, 32'd0);
        chk("reset_addr", imemAddr, 32'd0);
        chk("reset_instr", instrD, 32'd0);
        chk("reset_pc4", pcPlus4D, 32'd0);
        chk("reset_valid", {31'b0, validD}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset_count", fetchCount, 32'd0);
`endif

        // c0: first issue right after release
        tick(); rstN = 1'b1; #3;
        chk("c0_req", {31'b0, imemReq}, 32'd1);
        chk("c0_addr", imemAddr, RESET_PC);
        tick(); #3;
        chk("c1_wait_no_req", {31'b0, imemReq}, 32'd0);
        tick(); #3;
        chk("c2_instr", instrD, 32'h00430820);
        chk("c2_pc4", pcPlus4D, 32'd4);
        chk("c2_valid", {31'b0, validD}, 32'd1);
        chk("c2_req", {31'b0, imemReq}, 32'd1);
        chk("c2_addr", imemAddr, 32'd4);

        // Stall while the addr-4 response arrives
        tick(); stallD = 1'b1; #3;
        chk("c3_no_req", {31'b0, imemReq}, 32'd0);
        tick(); #3;
        chk("c4_instr", instrD, mem_word(32'd4));
        chk("c4_pc4", pcPlus4D, 32'd8);
        chk("c4_valid", {31'b0, validD}, 32'd1);
        chk("c4_stall_no_req", {31'b0, imemReq}, 32'd0);
        tick(); #3;
        chk("c5_stall_no_req", {31'b0, imemReq}, 32'd0);
        chk("c5_instr", instrD, mem_word(32'd4));
        tick(); stallD = 1'b0; lat_cfg = 2; #3;
        chk("c6_req", {31'b0, imemReq}, 32'd1);
        chk("c6_addr", imemAddr, 32'd8);

        // Redirect while WAIT, response two cycles after request
        tick(); redirect(32'h00000103); #3;
        chk("c7_no_req", {31'b0, imemReq}, 32'd0);
        tick(); pcSrcD = 1'b0; #3;
        chk("c8_drop_no_req", {31'b0, imemReq}, 32'd0);
        chk("c8_valid", {31'b0, validD}, 32'd0);
        tick(); lat_cfg = 1; #3;
        chk("c9_req", {31'b0, imemReq}, 32'd1);
        chk("c9_addr", imemAddr, 32'h00000100);
        chk("c9_valid", {31'b0, validD}, 32'd0);

        // Redirect in the same cycle as the response
        tick(); redirect(32'h00000200); #3;
        chk("c10_no_req", {31'b0, imemReq}, 32'd0);
        tick(); pcSrcD = 1'b0; #3;
        chk("c11_valid", {31'b0, validD}, 32'd0);
        chk("c11_req", {31'b0, imemReq}, 32'd1);
        chk("c11_addr", imemAddr, 32'h00000200);
        tick(); #3;

        // Wrap-around: redirect to the top word
        tick(); redirect(32'hFFFFFFFF); #3;
        chk("c13_instr", instrD, mem_word(32'h00000200));
        chk("c13_pc4", pcPlus4D, 32'h00000204);
        chk("c13_valid", {31'b0, validD}, 32'd1);
        chk("c13_no_req", {31'b0, imemReq}, 32'd0);
        tick(); pcSrcD = 1'b0; #3;
        chk("c14_valid", {31'b0, validD}, 32'd0);
        chk("c14_addr", imemAddr, 32'hFFFFFFFC);
        tick(); #3;
        tick(); lat_cfg = 3; #3;
        chk("c16_instr", instrD, mem_word(32'hFFFFFFFC));
        chk("c16_pc4_wrap", pcPlus4D, 32'h00000000);
        chk("c16_req", {31'b0, imemReq}, 32'd1);
        chk("c16_addr_wrap", imemAddr, 32'h00000000);
`ifdef FETCH_PERF_CNT_EN
        chk("c16_count", fetchCount, 32'd4);
`endif

        // Reset mid-WAIT; the late response lands in the release cycle
        tick(); rstN = 1'b0; #3;
        chk("c17_rst_req", {31'b0, imemReq}, 32'd0);
        chk("c17_rst_valid", {31'b0, validD}, 32'd0);
        chk("c17_rst_instr", instrD, 32'd0);
        tick(); #3;
        tick(); rstN = 1'b1; lat_cfg = 1; #3;
        chk("c19_late_resp_present", {31'b0, imemValid}, 32'd1);
        chk("c19_req", {31'b0, imemReq}, 32'd1);
        chk("c19_addr", imemAddr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("c19_count", fetchCount, 32'd0);
`endif
        tick(); #3;
        tick(); #3;
        chk("c21_instr", instrD, mem_word(RESET_PC));
        chk("c21_pc4", pcPlus4D, RESET_PC + 32'd4);
        chk("c21_valid", {31'b0, validD}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("c21_count", fetchCount, 32'd1);
`endif

        // Randomized stall / redirect traffic with random memory latency
        consumed_start = consumed;
        lat_cfg = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stallD = (($urandom % 4) == 0);
            if (($urandom % 20) == 0) begin
                t = $urandom;
                if (($urandom % 3) == 0) t = 32'hFFFFFFF0 | (t & 32'h0000000F);
                redirect(t);
            end else begin
                pcSrcD = 1'b0;
            end
        end
        tick(); stallD = 1'b0; pcSrcD = 1'b0;
        repeat (20) tick();
        #3;
        chk("random_progress", {31'b0, (consumed - consumed_start) >= 200}, 32'd1);
        chk("redirect_queue_drained", redir_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
